dist_filter_zone: RTL and testbench

Downstream stage of the HC-SR04 ultrasonic ranger. Consumes the ranger's 9-bit centimetre result and its level-style `valid` flag, which is generated in the ranger's slow microsecond domain. It produces a 4-sample moving-average distance, a debounced near/mid/far zone with hysteresis, and a proximity alarm for the display/actuator logic.

---
 rtl/dist_filter_zone.sv | 140 ++++++++++++++
 tb/tb_dist_filter_zone.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dist_filter_zone.sv
// dist_filter_zone: 4-sample moving average, hysteretic near/mid/far zone and proximity alarm; optional timeout via DIST_FILT_TIMEOUT_EN
module dist_filter_zone #(
    parameter int NEAR_CM     = 20,
    parameter int FAR_CM      = 50,
    parameter int HYST_CM     = 3,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] distancia_cm,
    input  logic       valid,
    output logic [8:0] dist_avg,
    output logic       avg_valid,
    output logic [1:0] zona,
    output logic       alarma,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE, SHIFT, SUM, OUT} state_t;
    localparam logic [1:0] Z_UNK  = 2'd0;
    localparam logic [1:0] Z_NEAR = 2'd1;
    localparam logic [1:0] Z_MID  = 2'd2;
    localparam logic [1:0] Z_FAR  = 2'd3;
    localparam logic [8:0] NEAR_TH = 9'(NEAR_CM);
    localparam logic [8:0] FAR_TH  = 9'(FAR_CM);
    localparam logic [8:0] NEAR_HI = 9'(NEAR_CM + HYST_CM);
    localparam logic [8:0] FAR_LO  = 9'(FAR_CM - HYST_CM);
    state_t      state_q;
    logic        v1_q, v2_q, v3_q;
    logic        acc, expire;
    logic [8:0]  sample_q, w0_q, w1_q, w2_q, w3_q;
    logic [2:0]  n_q;
    logic [10:0] sum_q;
    logic [8:0]  avg_d, dist_avg_q;
    logic [1:0]  plain_d, zona_d, zona_q;
    logic        avg_valid_q, alarma_q;

    assign acc       = v2_q & ~v3_q;
    assign avg_d     = sum_q[10:2];
    assign dist_avg  = dist_avg_q;
    assign avg_valid = avg_valid_q;
    assign zona      = zona_q;
    assign alarma    = alarma_q;

    // two-flop synchroniser for the slow-domain valid plus an edge-history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // hysteresis: leaving NEAR or FAR needs the average to clear the band first
    always_comb begin
        plain_d = (avg_d < NEAR_TH) ? Z_NEAR : (avg_d > FAR_TH) ? Z_FAR : Z_MID;
        zona_d  = (zona_q == Z_NEAR && avg_d < NEAR_HI) ? Z_NEAR :
                  (zona_q == Z_FAR && avg_d > FAR_LO) ? Z_FAR : plain_d;
    end

`ifdef DIST_FILT_TIMEOUT_EN
    localparam logic [22:0] TO_LAST = 23'(TIMEOUT_CYC - 1);
    logic [22:0] cnt_q, cnt_d;
    logic        timeout_q;
    assign expire  = ~acc & (cnt_q == TO_LAST);
    assign cnt_d   = acc ? '0 : expire ? cnt_q : cnt_q + 23'd1;
    assign timeout = timeout_q;

    // silence counter: holds at expiry, a new sample always wins over expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= acc ? 1'b0 : expire ? 1'b1 : timeout_q;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = |32'(TIMEOUT_CYC);
    assign expire     = 1'b0;
    assign timeout    = 1'b0;
`endif

    // capture -> shift window -> sum -> publish; samples arriving mid-pipeline are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            w3_q        <= '0;
            n_q         <= '0;
            sum_q       <= '0;
            dist_avg_q  <= '0;
            avg_valid_q <= 1'b0;
            zona_q      <= Z_UNK;
            alarma_q    <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (acc) begin
                    sample_q <= distancia_cm;
                    state_q  <= SHIFT;
                end
                SHIFT: begin
                    w0_q    <= sample_q;
                    w1_q    <= w0_q;
                    w2_q    <= w1_q;
                    w3_q    <= w2_q;
                    n_q     <= (n_q == 3'd4) ? n_q : n_q + 3'd1;
                    state_q <= SUM;
                end
                SUM: begin
                    sum_q   <= 11'(w0_q) + 11'(w1_q) + 11'(w2_q) + 11'(w3_q);
                    state_q <= OUT;
                end
                default: begin
                    if (n_q == 3'd4) begin
                        dist_avg_q  <= avg_d;
                        avg_valid_q <= 1'b1;
                        zona_q      <= zona_d;
                        alarma_q    <= (zona_d == Z_NEAR);
                    end
                    state_q <= IDLE;
                end
            endcase
            if (expire) begin
                n_q      <= '0;
                zona_q   <= Z_UNK;
                alarma_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dist_filter_zone.sv
// tb_dist_filter_zone: randomized measurements checked against a per-measurement average/zone model
module tb_dist_filter_zone;
    logic       clk = 1'b0;
    logic       rst, valid, avg_valid, alarma, timeout;
    logic [8:0] distancia_cm, dist_avg;
    logic [1:0] zona;
    int checks = 0, failures = 0;
    int win[$];
    int fill = 0, m_avg = 0, m_zone = 0, m_to = 0;
`ifdef DIST_FILT_TIMEOUT_EN
    bit to_en = 1'b1;
`else
    bit to_en = 1'b0;
`endif

    dist_filter_zone #(.NEAR_CM(20), .FAR_CM(50), .HYST_CM(3), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .rst(rst), .distancia_cm(distancia_cm), .valid(valid),
        .dist_avg(dist_avg), .avg_valid(avg_valid), .zona(zona), .alarma(alarma), .timeout(timeout)
    );

    always #10 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int zone_next(int z, int a);
        int plain = a < 20 ? 1 : (a > 50 ? 3 : 2);
        if (z == 1 && a < 23) return 1;
        if (z == 3 && a > 47) return 3;
        return plain;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        win.delete();
        fill   = 0;
        m_zone = 0;
    endtask

    task automatic measure(int d, int hi, int lo);
        int pulses = 0, first = 0, idx = 0;
        int exp_pulse;
        win.push_back(d);
        if (win.size() > 4) void'(win.pop_front());
        fill      = fill < 4 ? fill + 1 : 4;
        exp_pulse = (fill == 4) ? 1 : 0;
        if (exp_pulse == 1) begin
            m_avg  = win.sum() / 4;
            m_zone = zone_next(m_zone, m_avg);
        end
        m_to = 0;
        if (to_en && hi + lo > 1003) begin
            model_clear();
            m_to = 1;
        end
        distancia_cm = 9'(d);
        valid = 1'b1;
        for (int i = 0; i < hi + lo; i++) begin
            if (i == hi) begin
                valid = 1'b0;
                distancia_cm = 9'($urandom_range(0, 511));
            end
            tick();
            idx++;
            if (avg_valid) begin
                pulses++;
                if (first == 0) first = idx;
            end
        end
        chk("pulses", pulses, exp_pulse);
        if (exp_pulse == 1) chk("latency", first, 6);
        chk("dist_avg", int'(dist_avg), m_avg);
        chk("zona", int'(zona), m_zone);
        chk("alarma", int'(alarma), m_zone == 1 ? 1 : 0);
        chk("timeout", int'(timeout), m_to);
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b1;
        distancia_cm = 9'd77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_avg_valid", int'(avg_valid), 0);
        end
        chk("rst_dist_avg", int'(dist_avg), 0);
        chk("rst_zona", int'(zona), 0);
        chk("rst_alarma", int'(alarma), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        valid = 1'b0;
        repeat (5) tick();

        measure(40, 200, 100);
        measure(41, 200, 100);
        measure(42, 200, 100);
        measure(44, 200, 100);

        repeat (4) measure(15, 30, 20);
        repeat (4) measure(21, 30, 20);
        repeat (2) measure(25, 30, 20);

        repeat (4) measure(60, 30, 20);
        repeat (4) measure(48, 30, 20);
        measure(47, 30, 20);

        for (int i = 0; i < 40; i++)
            measure(int'($urandom_range(0, 100)), int'($urandom_range(10, 60)), int'($urandom_range(5, 30)));
        for (int i = 0; i < 30; i++)
            measure(int'($urandom_range(14, 56)), int'($urandom_range(10, 40)), int'($urandom_range(5, 20)));

        measure(33, 10000, 20);
        repeat (4) measure(70, 30, 20);

        distancia_cm = 9'd90;
        valid = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        valid = 1'b0;
        tick();
        chk("sum_rst_avg_valid", int'(avg_valid), 0);
        rst = 1'b0;
        model_clear();
        m_avg = 0;
        begin
            int pulses = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (avg_valid) pulses++;
            end
            chk("sum_rst_pulses", pulses, 0);
        end
        chk("sum_rst_dist_avg", int'(dist_avg), 0);
        chk("sum_rst_zona", int'(zona), 0);
        repeat (4) measure(15, 30, 20);

        repeat (1100) tick();
        if (to_en) begin
            model_clear();
            m_to = 1;
        end
        chk("idle_timeout", int'(timeout), m_to);
        chk("idle_zona", int'(zona), m_zone);
        chk("idle_alarma", int'(alarma), m_zone == 1 ? 1 : 0);
        chk("idle_dist_avg", int'(dist_avg), m_avg);
        repeat (4) measure(30, 30, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
